axi_slave_mem: RTL and testbench

AXI4 slave responder with an internal word-addressed memory; the completion partner to the bus master/VIP driving the AW/W/B/AR/R channels on intf.
Independent write and read engines accept one burst each at a time; it supports FIXED, INCR and WRAP bursts with byte strobes.
The block serves as the DUT/reference target for the VIP and must never violate the interface's protocol assertions.

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_burst_addr_gen.sv | 33 +++
 rtl/axi_slave_mem.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared encodings for the AXI4 slave memory: burst types, response codes
// and the write/read engine state sets.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational beat-to-beat address stepping and burst legality check for
// one AXI burst (FIXED / INCR / WRAP; reserved burst type steps like INCR).
module axi_burst_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              burst_err
);
  import axi_pkg::*;

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    inc       = ADDR_W'(1) << size;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      FIXED:   next_addr = addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | ((addr + inc) & wrap_mask);
      default: next_addr = addr + inc;
    endcase
    burst_err = (size > 3'd2) || (burst == 2'b11);
    if (burst == WRAP) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) burst_err = 1'b1;
      if ((addr & (inc - ADDR_W'(1))) != '0)       burst_err = 1'b1;
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave with a word-addressed internal memory. Independent write and read
// engines, one burst each in flight; reads see memory before same-edge writes.
module axi_slave_mem #(
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              w_last,
  input  logic [31:0]       w_data,
  input  logic [3:0]        w_strb,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [1:0]        b_resp,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_last,
  output logic [31:0]       r_data,
  output logic [1:0]        r_resp
);
  import axi_pkg::*;

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [MEM_DEPTH-1:0][31:0] mem;
  logic out_en;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < ADDR_W'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  function automatic logic [31:0] rd_data(input logic [ADDR_W-1:0] a, input logic err);
    return (!err && in_range(a)) ? mem[word_idx(a)] : 32'd0;
  endfunction

  function automatic logic [1:0] rd_resp(input logic [ADDR_W-1:0] a, input logic err);
    return (!err && in_range(a)) ? OKAY : SLVERR;
  endfunction

  // Holds the address-ready outputs low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_en <= 1'b0;
    else        out_en <= 1'b1;
  end

  // ---------------- write engine ----------------
  w_state_e          w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr, wg_next;
  logic [7:0]        w_len, w_beat;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, wg_err, w_final;
  logic              aw_hs, w_hs, b_hs;
  logic [31:0]       w_merged;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
    .next_addr(wg_next), .burst_err(wg_err)
  );

  assign aw_hs   = aw_valid && aw_ready;
  assign w_hs    = w_valid && w_ready;
  assign b_hs    = b_valid && b_ready;
  assign w_final = (w_beat == w_len);

  always_comb begin
    w_state_nx = w_state;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    b_resp     = OKAY;
    w_merged   = mem[word_idx(w_addr)];
    for (int b = 0; b < 4; b++)
      if (w_strb[b]) w_merged[8*b +: 8] = w_data[8*b +: 8];
    case (w_state)
      W_IDLE: begin
        aw_ready = out_en;
        if (aw_hs) w_state_nx = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (w_hs && w_final) w_state_nx = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        b_resp  = w_err ? SLVERR : OKAY;
        if (b_hs) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
      mem     <= '0;
    end else begin
      w_state <= w_state_nx;
      if (aw_hs) begin
        w_addr  <= aw_addr;
        w_len   <= aw_len;
        w_size  <= aw_size;
        w_burst <= aw_burst;
        w_beat  <= '0;
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_addr <= wg_next;
        w_beat <= w_beat + 8'd1;
        // A w_last that disagrees with the beat count is an error but never ends the burst early.
        w_err  <= w_err | wg_err | !in_range(w_addr) | (w_last != w_final);
        if (!wg_err && in_range(w_addr)) mem[word_idx(w_addr)] <= w_merged;
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_e          r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr, rg_addr, rg_next;
  logic [7:0]        r_len, r_beat, rg_len;
  logic [2:0]        r_size, rg_size;
  logic [1:0]        r_burst, rg_burst;
  logic              rg_err, ar_hs, r_hs;

  // While idle the generator checks the incoming AR so beat 0 loads on the handshake edge.
  assign rg_addr  = (r_state == R_IDLE) ? ar_addr  : r_addr;
  assign rg_len   = (r_state == R_IDLE) ? ar_len   : r_len;
  assign rg_size  = (r_state == R_IDLE) ? ar_size  : r_size;
  assign rg_burst = (r_state == R_IDLE) ? ar_burst : r_burst;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
    .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
    .next_addr(rg_next), .burst_err(rg_err)
  );

  assign ar_hs = ar_valid && ar_ready;
  assign r_hs  = r_valid && r_ready;

  always_comb begin
    r_state_nx = r_state;
    ar_ready   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = out_en;
        if (ar_hs) r_state_nx = R_DATA;
      end
      R_DATA: if (r_hs && r_last) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= OKAY;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      if (ar_hs) begin
        r_addr  <= ar_addr;
        r_len   <= ar_len;
        r_size  <= ar_size;
        r_burst <= ar_burst;
        r_beat  <= '0;
        r_valid <= 1'b1;
        r_data  <= rd_data(ar_addr, rg_err);
        r_resp  <= rd_resp(ar_addr, rg_err);
        r_last  <= (ar_len == 8'd0);
      end else if (r_hs) begin
        if (r_last) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_data  <= '0;
          r_resp  <= OKAY;
        end else begin
          r_addr  <= rg_next;
          r_beat  <= r_beat + 8'd1;
          r_data  <= rd_data(rg_next, rg_err);
          r_resp  <= rd_resp(rg_next, rg_err);
          r_last  <= ((r_beat + 8'd1) == r_len);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: tasks drive directed bursts and queue the
// expected B/R responses; negedge monitors pop and compare on each handshake.
module tb_axi_slave_mem;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        aw_valid = 0, aw_ready;
  logic [31:0] aw_addr = 0;
  logic [7:0]  aw_len = 0;
  logic [2:0]  aw_size = 0;
  logic [1:0]  aw_burst = 0;
  logic        w_valid = 0, w_ready, w_last = 0;
  logic [31:0] w_data = 0;
  logic [3:0]  w_strb = 0;
  logic        b_valid, b_ready = 0;
  logic [1:0]  b_resp;
  logic        ar_valid = 0, ar_ready;
  logic [31:0] ar_addr = 0;
  logic [7:0]  ar_len = 0;
  logic [2:0]  ar_size = 0;
  logic [1:0]  ar_burst = 0;
  logic        r_valid, r_ready = 0, r_last;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  always #5 clk = ~clk;

  axi_slave_mem #(.ADDR_W(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_data(r_data), .r_resp(r_resp)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  rexp_t       r_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] wd[16];
  logic [3:0]  ws[16];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
    rexp_t e;
    e.d = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (b_valid && b_ready) begin
      if (b_q.size() == 0) chk("b_unexpected", 32'(b_resp), 32'hFFFF_FFFF);
      else                 chk("b_resp", 32'(b_resp), 32'(b_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (r_valid && r_ready) begin
      if (r_q.size() == 0) chk("r_unexpected", r_data, 32'hDEAD_BEEF);
      else begin
        rexp_t e;
        e = r_q.pop_front();
        chk("r_data", r_data, e.d);
        chk("r_resp_last", {r_resp, r_last}, {e.resp, e.last});
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [15:0] lastmask,
                          input logic [1:0] exp_resp, input int bdelay);
    int n;
    b_q.push_back(exp_resp);
    @(posedge clk); #1;
    aw_valid = 1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    @(negedge clk);
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_ready_timeout", 0, 1);
    @(posedge clk); #1;
    aw_valid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1; w_data = wd[i]; w_strb = ws[i]; w_last = lastmask[i];
      @(negedge clk);
      if (i == 0) chk("w_ready_after_aw", {w_ready, aw_ready}, 2'b10);
      n = 0;
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    w_valid = 0; w_last = 0;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk);
      chk("b_hold", {b_valid, aw_ready, b_resp}, {2'b10, exp_resp});
      @(posedge clk); #1;
    end
    b_ready = 1;
    @(negedge clk);
    chk("b_valid", b_valid, 1);
    @(posedge clk); #1;
    b_ready = 0;
    @(negedge clk);
    chk("aw_ready_after_b", {b_valid, aw_ready}, 2'b01);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int stall_beat, input int stall_n);
    int n, beat, stalled, cyc;
    logic [31:0] hd;
    logic        hl;
    hd = 0; hl = 0;
    @(posedge clk); #1;
    ar_valid = 1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    @(negedge clk);
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_ready_timeout", 0, 1);
    @(posedge clk); #1;
    ar_valid = 0;
    beat = 0; stalled = 0; cyc = 0;
    r_ready = !(stall_beat == 0 && stall_n > 0);
    while (beat <= int'(len) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("r_valid_first", r_valid, 1);
      if (r_valid && r_ready) beat++;
      else if (!r_ready) begin
        if (stalled == 0) begin hd = r_data; hl = r_last; end
        else chk("r_stall_stable", {r_valid, r_last, r_data}, {1'b1, hl, hd});
        stalled++;
      end
      @(posedge clk); #1;
      r_ready = !(beat == stall_beat && stalled < stall_n);
    end
    if (cyc >= 200) chk("r_timeout", 0, 1);
    r_ready = 0;
    @(negedge clk);
    chk("r_idle_after", {r_valid, ar_ready}, 2'b01);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_last, r_resp}, 0);
    chk("reset_rdata", r_data, 0);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("aw_ready_before_edge", {aw_ready, ar_ready}, 2'b00);
    @(negedge clk);
    chk("aw_ready_after_release", {aw_ready, ar_ready}, 2'b11);

    // INCR write/read of 0x10..0x1C
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h10, 8'd3, 3'd2, INCR, 16'h0008, OKAY, 0);
    for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OKAY, i == 3);
    do_read(32'h10, 8'd3, 3'd2, INCR, -1, 0);

    // WRAP read: 0x38, 0x3C, 0x30, 0x34
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h30, 8'd3, 3'd2, INCR, 16'h0008, OKAY, 0);
    push_r(32'hB2, OKAY, 0); push_r(32'hB3, OKAY, 0);
    push_r(32'hB0, OKAY, 0); push_r(32'hB1, OKAY, 1);
    do_read(32'h38, 8'd3, 3'd2, WRAP, -1, 0);

    // WRAP with illegal len=2
    for (int i = 0; i < 3; i++) push_r(32'h0, SLVERR, i == 2);
    do_read(32'h30, 8'd2, 3'd2, WRAP, -1, 0);

    // partial strobe merge
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(32'h20, 8'd0, 3'd2, INCR, 16'h0001, OKAY, 0);
    wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
    do_write(32'h20, 8'd0, 3'd2, INCR, 16'h0001, OKAY, 0);
    push_r(32'hFF34_FF78, OKAY, 1);
    do_read(32'h20, 8'd0, 3'd2, INCR, -1, 0);

    // last in-range word then out of range
    wd[0] = 32'hC0; wd[1] = 32'hC1; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'hFFC, 8'd1, 3'd2, INCR, 16'h0002, SLVERR, 0);
    push_r(32'hC0, OKAY, 0); push_r(32'h0, SLVERR, 1);
    do_read(32'hFFC, 8'd1, 3'd2, INCR, -1, 0);

    // FIXED burst lands every beat on one word
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hD0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h50, 8'd2, 3'd2, FIXED, 16'h0004, OKAY, 0);
    push_r(32'hD2, OKAY, 1);
    do_read(32'h50, 8'd0, 3'd2, INCR, -1, 0);

    // early w_last: burst still runs to len+1, response is SLVERR
    wd[0] = 32'hE0; wd[1] = 32'hE1; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h60, 8'd1, 3'd2, INCR, 16'h0003, SLVERR, 0);
    push_r(32'hE0, OKAY, 0); push_r(32'hE1, OKAY, 1);
    do_read(32'h60, 8'd1, 3'd2, INCR, -1, 0);

    // backpressure on R and B
    for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), OKAY, i == 3);
    do_read(32'h10, 8'd3, 3'd2, INCR, 1, 5);
    wd[0] = 32'h55; ws[0] = 4'hF;
    do_write(32'h40, 8'd0, 3'd2, INCR, 16'h0001, OKAY, 3);

    // reset during beat 2 of a write burst
    @(posedge clk); #1;
    aw_valid = 1; aw_addr = 32'h10; aw_len = 8'd3; aw_size = 3'd2; aw_burst = INCR;
    @(negedge clk);
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_ready_timeout", 0, 1);
    @(posedge clk); #1;
    aw_valid = 0;
    for (int i = 0; i < 2; i++) begin
      w_valid = 1; w_data = 32'h77 + 32'(i); w_strb = 4'hF; w_last = 0;
      @(negedge clk);
      chk("w_ready_mid", w_ready, 1);
      @(posedge clk); #1;
    end
    w_valid = 1; w_data = 32'h79;
    @(negedge clk);
    reset = 0;
    #1;
    chk("reset_mid_outputs", {aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_last, r_resp}, 0);
    chk("reset_mid_rdata", r_data, 0);
    w_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("aw_ready_before_edge2", aw_ready, 0);
    @(negedge clk);
    chk("aw_ready_after_release2", aw_ready, 1);
    push_r(32'h0, OKAY, 1);
    do_read(32'h10, 8'd0, 3'd2, INCR, -1, 0);

    @(negedge clk);
    chk("b_queue_empty", 32'(b_q.size()), 0);
    chk("r_queue_empty", 32'(r_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
